// File: rtl/bit_collector16.sv
// Serial-to-parallel bit collector: assembles one bit per handshake into a WIDTH-bit word
// using the same slot mapping as the 16:1 select mux, and presents words on a valid/ready port.
module bit_collector16 #(
    parameter int unsigned WIDTH     = 16,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned IDXW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  slot_idx
);

    localparam logic [IDXW-1:0] LAST_SLOT = IDXW'(WIDTH - 1);

    logic [IDXW-1:0]  slot_q, slot_d;
    logic [WIDTH-1:0] asm_q, asm_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             last_slot;
    logic             acc;
    logic [IDXW-1:0]  pos;
    logic [WIDTH-1:0] merged;

    // Only the completing bit can stall, and only while the output word is still unclaimed.
    assign last_slot = (slot_q == LAST_SLOT);
    assign in_ready  = !flush && (!last_slot || !out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;

    always_comb begin
        pos            = MSB_FIRST ? (LAST_SLOT - slot_q) : slot_q;
        merged         = asm_q;
        merged[pos]    = in_bit;
    end

    always_comb begin
        slot_d      = slot_q;
        asm_d       = asm_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (flush) begin
            slot_d = '0;
            asm_d  = '0;
        end else if (acc) begin
            slot_d = slot_q + IDXW'(1);
            if (last_slot) begin
                asm_d       = '0;
                out_data_d  = merged;
                out_valid_d = 1'b1;
            end else begin
                asm_d = merged;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q      <= '0;
            asm_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            slot_q      <= slot_d;
            asm_q       <= asm_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign slot_idx  = slot_q;

endmodule

// File: tb/tb_bit_collector16.sv
// Directed bench for bit_collector16: MSB-first and LSB-first instances share all inputs.
module tb_bit_collector16;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_bit;
    logic        out_ready;

    logic        m_in_ready, m_out_valid;
    logic [15:0] m_out_data;
    logic [3:0]  m_slot_idx;
    logic        l_in_ready, l_out_valid;
    logic [15:0] l_out_data;
    logic [3:0]  l_slot_idx;

    int tests = 0;
    int fails = 0;

    bit_collector16 #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(m_in_ready), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_data(m_out_data), .slot_idx(m_slot_idx)
    );

    bit_collector16 #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(l_in_ready), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_data(l_out_data), .slot_idx(l_slot_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams w in slot order: slot 0 carries w[15].
    task automatic send_word(input logic [15:0] w);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_bit   = w[15 - i];
            step();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", m_out_valid); end
        tests++; if (m_out_data !== 16'h0000) begin fails++; $display("FAIL reset_out_data: got %h expected 0000", m_out_data); end
        tests++; if (m_slot_idx !== 4'd0) begin fails++; $display("FAIL reset_slot_idx: got %0d expected 0", m_slot_idx); end
        tests++; if (m_in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", m_in_ready); end
    endtask

    task automatic test_basic();
        logic [15:0] w;
        w = 16'hA5C3;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_bit   = w[15 - i];
            #1;
            tests++; if (m_in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready bit %0d: got %b expected 1", i, m_in_ready); end
            tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid bit %0d: got %b expected 0", i, m_out_valid); end
            step();
        end
        in_valid = 1'b0;
        tests++; if (m_out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid: got %b expected 1", m_out_valid); end
        tests++; if (m_out_data !== 16'hA5C3) begin fails++; $display("FAIL basic_out_data: got %h expected a5c3", m_out_data); end
        tests++; if (m_slot_idx !== 4'd0) begin fails++; $display("FAIL basic_slot_idx: got %0d expected 0", m_slot_idx); end
        step();
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL basic_single_pulse: got %b expected 0", m_out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_word(16'hA5C3);
        tests++; if (m_out_valid !== 1'b1) begin fails++; $display("FAIL bp_first_valid: got %b expected 1", m_out_valid); end
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            #1;
            tests++; if (m_in_ready !== 1'b1) begin fails++; $display("FAIL bp_in_ready bit %0d: got %b expected 1", i, m_in_ready); end
            step();
            tests++; if (m_out_data !== 16'hA5C3) begin fails++; $display("FAIL bp_hold bit %0d: got %h expected a5c3", i, m_out_data); end
        end
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        tests++; if (m_in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready: got %b expected 0", m_in_ready); end
        tests++; if (m_slot_idx !== 4'd15) begin fails++; $display("FAIL bp_stall_slot: got %0d expected 15", m_slot_idx); end
        step();
        tests++; if (m_slot_idx !== 4'd15) begin fails++; $display("FAIL bp_stall_slot_held: got %0d expected 15", m_slot_idx); end
        tests++; if (m_out_data !== 16'hA5C3 || m_out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall_hold: got %h/%b expected a5c3/1", m_out_data, m_out_valid); end
        out_ready = 1'b1;
        #1;
        tests++; if (m_in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b expected 1", m_in_ready); end
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        tests++; if (m_out_valid !== 1'b1) begin fails++; $display("FAIL bp_second_valid: got %b expected 1", m_out_valid); end
        tests++; if (m_out_data !== 16'hFFFF) begin fails++; $display("FAIL bp_second_data: got %h expected ffff", m_out_data); end
        tests++; if (m_slot_idx !== 4'd0) begin fails++; $display("FAIL bp_second_slot: got %0d expected 0", m_slot_idx); end
        out_ready = 1'b1;
        step();
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b expected 0", m_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] stream;
        logic        exp_v;
        stream    = {16'h1234, 16'h8001};
        out_ready = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            in_valid = 1'b1;
            in_bit   = stream[32 - k];
            #1;
            tests++; if (m_in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready bit %0d: got %b expected 1", k, m_in_ready); end
            step();
            exp_v = (k == 16) || (k == 32);
            tests++; if (m_out_valid !== exp_v) begin fails++; $display("FAIL b2b_valid after bit %0d: got %b expected %b", k, m_out_valid, exp_v); end
            if (k == 16) begin
                tests++; if (m_out_data !== 16'h1234) begin fails++; $display("FAIL b2b_word1: got %h expected 1234", m_out_data); end
            end
            if (k == 32) begin
                tests++; if (m_out_data !== 16'h8001) begin fails++; $display("FAIL b2b_word2: got %h expected 8001", m_out_data); end
            end
        end
        in_valid = 1'b0;
        step();
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b expected 0", m_out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            step();
        end
        tests++; if (m_slot_idx !== 4'd7) begin fails++; $display("FAIL flush_pre_slot: got %0d expected 7", m_slot_idx); end
        in_valid = 1'b1;
        in_bit   = 1'b1;
        flush    = 1'b1;
        #1;
        tests++; if (m_in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready: got %b expected 0", m_in_ready); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        tests++; if (m_slot_idx !== 4'd0) begin fails++; $display("FAIL flush_slot: got %0d expected 0", m_slot_idx); end
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL flush_no_valid: got %b expected 0", m_out_valid); end
        send_word(16'h0F0F);
        tests++; if (m_out_valid !== 1'b1) begin fails++; $display("FAIL flush_word_valid: got %b expected 1", m_out_valid); end
        tests++; if (m_out_data !== 16'h0F0F) begin fails++; $display("FAIL flush_word_data: got %h expected 0f0f", m_out_data); end
        step();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        send_word(16'hA5C3);
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_bit   = 1'b1;
            step();
        end
        in_valid = 1'b0;
        tests++; if (m_slot_idx !== 4'd9 || m_out_valid !== 1'b1) begin fails++; $display("FAIL mrst_pre: got slot %0d valid %b expected 9/1", m_slot_idx, m_out_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        tests++; if (m_out_valid !== 1'b0) begin fails++; $display("FAIL mrst_out_valid: got %b expected 0", m_out_valid); end
        tests++; if (m_out_data !== 16'h0000) begin fails++; $display("FAIL mrst_out_data: got %h expected 0000", m_out_data); end
        tests++; if (m_slot_idx !== 4'd0) begin fails++; $display("FAIL mrst_slot: got %0d expected 0", m_slot_idx); end
        tests++; if (m_in_ready !== 1'b1) begin fails++; $display("FAIL mrst_in_ready: got %b expected 1", m_in_ready); end
        send_word(16'h5A5A);
        tests++; if (m_out_valid !== 1'b1 || m_out_data !== 16'h5A5A) begin fails++; $display("FAIL mrst_word: got %h/%b expected 5a5a/1", m_out_data, m_out_valid); end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_lsb_first();
        out_ready = 1'b1;
        send_word(16'h8000);
        tests++; if (l_out_valid !== 1'b1 || l_out_data !== 16'h0001) begin fails++; $display("FAIL lsb_single: got %h/%b expected 0001/1", l_out_data, l_out_valid); end
        tests++; if (m_out_data !== 16'h8000) begin fails++; $display("FAIL lsb_msb_ref: got %h expected 8000", m_out_data); end
        send_word(16'hA5C3);
        tests++; if (l_out_valid !== 1'b1 || l_out_data !== 16'hC3A5) begin fails++; $display("FAIL lsb_reversed: got %h/%b expected c3a5/1", l_out_data, l_out_valid); end
        step();
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_lsb_first();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_collector16.md
Name: bit_collector16

Overview:
- Serial-to-parallel bit collector. It is the write-side counterpart of the 16:1 single-bit select mux.
- Accepts one bit per handshake and places it at a 4-bit slot index. Slot mapping is identical to the mux: slot i lands at word[WIDTH-1-i] when MSB_FIRST=1.
- Presents each completed word on a registered valid/ready output.
- Used wherever the CPU rebuilds a parallel word from a bit stream (debug/shift paths, bit-serial peripherals).

Parameters:
- WIDTH, 16, word width in bits; must be a power of two, at least 2.
- MSB_FIRST, 1, slot mapping. 1: slot i lands at word[WIDTH-1-i]. 0: slot i lands at word[i].
- IDXW, $clog2(WIDTH), slot index width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard the partial word being collected.
- in_valid  input  1  in_bit is valid.
- in_bit  input  1  serial data bit.
- in_ready  output  1  bit accepted this cycle when in_valid && in_ready.
- out_valid  output  1  out_data holds a completed word.
- out_ready  input  1  consumer takes out_data when out_valid && out_ready.
- out_data  output  WIDTH  completed word.
- slot_idx  output  IDXW  index the next accepted bit will occupy.

Behaviour:
- Reset, sampled on a clk edge: slot_idx=0, assembly register=0, out_valid=0, out_data=0. in_ready is 1 in the cycle after reset. Reset wins over every other input, including mid-word and a pending out_valid.
- Accept condition: acc = in_valid && in_ready. On acc, assembly[pos(slot_idx)] <= in_bit and slot_idx <= slot_idx+1, wrapping from WIDTH-1 to 0.
- pos(i) = WIDTH-1-i when MSB_FIRST=1; pos(i) = i when MSB_FIRST=0.
- Completion: an acc with slot_idx==WIDTH-1 loads out_data <= assembly with the final bit merged in, and sets out_valid <= 1 on the same edge. In the same cycle the assembly register clears to 0.
- Latency: out_valid rises the cycle after the WIDTH-th accepted bit.
- Output handshake: out_valid && out_ready clears out_valid on the next edge unless a new completion occurs on that same edge. In that case out_valid stays 1 and out_data takes the new word.
- out_data is held stable while out_valid=1 and the word is not taken.
- in_ready is combinational: in_ready = !flush && (slot_idx != WIDTH-1 || !out_valid || out_ready).
  - Collection continues into the next word while the previous word is still pending.
  - Only the completing bit stalls, and only when the output register is still occupied.
- Throughput: one bit per cycle with no gaps when out_ready is held high. WIDTH bits give one word every WIDTH cycles.
- flush: on the edge it is sampled, slot_idx <= 0 and assembly <= 0. in_ready=0 while flush=1, so a bit presented in the same cycle is not accepted. flush does not touch out_valid or out_data.
- flush in the same cycle as an output handshake: both take effect.
- Unwritten slots of a word are never stale: every accepted word has all WIDTH bits written since the last clear.
- No X propagation: in_bit is sampled only on acc.

Test Plan:
- Basic MSB-first word: MSB_FIRST=1, out_ready=1. Send bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with in_valid held for 16 cycles. Expect in_ready=1 throughout, out_valid=1 for exactly one cycle, starting the cycle after the 16th bit, with out_data=16'hA5C3, and slot_idx back at 0.
- Output backpressure: out_ready=0, send 0xA5C3 followed by 16 bits of 0xFFFF.
  - The first 15 bits of the second word are accepted while out_data holds 0xA5C3.
  - The 16th bit sees in_ready=0 and slot_idx=15.
  - Raise out_ready for one cycle: the bit is accepted that cycle, and the next cycle shows out_valid=1 with out_data=16'hFFFF.
- Back-to-back throughput: out_ready=1, stream 32 bits for 0x1234 then 0x8001 continuously. Expect two out_valid pulses exactly 16 cycles apart, carrying 16'h1234 then 16'h8001, with no in_ready gaps.
- Partial-word flush:
  - Send 7 bits of 1. Pulse flush in the same cycle as an 8th in_valid: that bit is rejected.
  - Then send 0x0F0F. Expect out_data=16'h0F0F with no residue from the earlier ones, and slot_idx=0 after the flush.
- Mid-word reset: with a pending word 0xA5C3 (out_ready=0) and 9 bits collected, assert reset for one cycle. Expect out_valid=0, out_data=0, slot_idx=0, in_ready=1. The next 16 bits of 0x5A5A yield 16'h5A5A.
- LSB-first mapping: MSB_FIRST=0, send bit sequence 1 followed by fifteen 0s. Expect out_data=16'h0001.
